// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller.
// Holds the opcode constants, the NOP encoding, the forwarding-select
// encoding, the opcode classification and scoreboard entry structs, and the
// forwarding-source helper used by the top level.
package pipeline_hazard_ctrl_pkg;

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_OP_IMM = 7'h13;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'd0,
        FWD_MEM     = 2'd1,
        FWD_WB      = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic rs1_used;
        logic rs2_used;
        logic rd_wr;
        logic is_load;
    } op_class_t;

    // An entry only ever has wr_en set with a nonzero rd, so an x0 source
    // can never match it.
    typedef struct packed {
        logic [4:0] rd;
        logic       wr_en;
        logic       is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // The youngest in-flight writer wins: EX result is on ALU_OUT in the
    // memory stage next cycle, MEM result is the writeback value.
    function automatic fwd_sel_e fwd_select(logic [4:0] rs, logic used,
                                            sb_entry_t ex, sb_entry_t mem);
        if (used && ex.wr_en && ex.rd == rs)
            return FWD_MEM;
        else if (used && mem.wr_en && mem.rd == rs)
            return FWD_WB;
        else
            return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bus between the pipeline datapath and the hazard controller.
//   DEC_INSTRUCTION : instruction in the decode register (datapath -> ctrl)
//   BRANCH_TAKEN    : execute-stage redirect              (datapath -> ctrl)
//   STALL_FETCH, STALL_DECODE, BUBBLE_EXECUTE, FLUSH_DECODE : pipeline control
//   FWD_A_SEL, FWD_B_SEL : registered operand source selects for execute
//   STALL_COUNT, FLUSH_COUNT : saturating performance counters
// CNT_W must match the CNT_W of the controller it is connected to.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);

    logic [31:0]      DEC_INSTRUCTION;
    logic             BRANCH_TAKEN;
    logic             STALL_FETCH;
    logic             STALL_DECODE;
    logic             BUBBLE_EXECUTE;
    logic             FLUSH_DECODE;
    logic [1:0]       FWD_A_SEL;
    logic [1:0]       FWD_B_SEL;
    logic [CNT_W-1:0] STALL_COUNT;
    logic [CNT_W-1:0] FLUSH_COUNT;

    modport master (
        output DEC_INSTRUCTION, BRANCH_TAKEN,
        input  STALL_FETCH, STALL_DECODE, BUBBLE_EXECUTE, FLUSH_DECODE,
        input  FWD_A_SEL, FWD_B_SEL, STALL_COUNT, FLUSH_COUNT
    );

    modport slave (
        input  DEC_INSTRUCTION, BRANCH_TAKEN,
        output STALL_FETCH, STALL_DECODE, BUBBLE_EXECUTE, FLUSH_DECODE,
        output FWD_A_SEL, FWD_B_SEL, STALL_COUNT, FLUSH_COUNT
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_decode.sv
// hazard_decode: combinational RV32I opcode classifier.
//   opcode : instruction bits [6:0]
//   cls    : {rs1_used, rs2_used, rd_wr, is_load}
// Unlisted opcodes (FENCE, SYSTEM, illegal) neither read nor write.
module pipeline_hazard_ctrl_hazard_decode
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        // NOTE: default assignment first so every path drives cls (no latch).
        cls = '0;
        case (opcode)
            OP_OP:     cls = '{rs1_used: 1'b1, rs2_used: 1'b1, rd_wr: 1'b1, is_load: 1'b0};
            OP_LOAD:   cls = '{rs1_used: 1'b1, rs2_used: 1'b0, rd_wr: 1'b1, is_load: 1'b1};
            OP_OP_IMM: cls = '{rs1_used: 1'b1, rs2_used: 1'b0, rd_wr: 1'b1, is_load: 1'b0};
            OP_JALR:   cls = '{rs1_used: 1'b1, rs2_used: 1'b0, rd_wr: 1'b1, is_load: 1'b0};
            OP_JAL,
            OP_LUI,
            OP_AUIPC:  cls = '{rs1_used: 1'b0, rs2_used: 1'b0, rd_wr: 1'b1, is_load: 1'b0};
            OP_STORE,
            OP_BRANCH: cls = '{rs1_used: 1'b1, rs2_used: 1'b1, rd_wr: 1'b0, is_load: 1'b0};
            default:   cls = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage RV32I pipeline.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : pipeline_hazard_ctrl_if.slave (decode instruction and
//                branch in; stall/bubble/flush, forwarding selects and
//                performance counters out)
// A 3-entry scoreboard (EX, MEM, WB) mirrors the destination registers of
// in-flight instructions. Load-use hazards stall for LOAD_USE_STALL cycles,
// a taken branch flushes decode and bubbles execute and overrides any stall.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
)
(
    input  logic CLK,
    input  logic RST_N,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALL - 1);

    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    op_class_t  dec_cls;
    sb_entry_t  dec_entry;
    sb_entry_t  sb [3];

    logic [1:0]       stall_left;
    logic             load_use, stall_active, flush, bubble;
    fwd_sel_e         fwd_a_q, fwd_b_q;
    logic [CNT_W-1:0] stall_count, flush_count;

    assign dec_rd  = bus.DEC_INSTRUCTION[11:7];
    assign dec_rs1 = bus.DEC_INSTRUCTION[19:15];
    assign dec_rs2 = bus.DEC_INSTRUCTION[24:20];

    pipeline_hazard_ctrl_hazard_decode u_dec (
        .opcode (bus.DEC_INSTRUCTION[6:0]),
        .cls    (dec_cls)
    );

    // Writes to x0 are dropped here so they never look like a producer.
    always_comb begin
        dec_entry         = SB_EMPTY;
        dec_entry.wr_en   = dec_cls.rd_wr && (dec_rd != 5'd0);
        dec_entry.rd      = dec_entry.wr_en ? dec_rd : 5'd0;
        dec_entry.is_load = dec_entry.wr_en && dec_cls.is_load;
    end

    // A new load-use hazard is only recognised once the previous stall has
    // fully drained.
    assign load_use = (stall_left == 2'd0) && sb[SB_EX].is_load && sb[SB_EX].wr_en &&
                      ((dec_cls.rs1_used && dec_rs1 == sb[SB_EX].rd) ||
                       (dec_cls.rs2_used && dec_rs2 == sb[SB_EX].rd));

    assign stall_active = (stall_left != 2'd0) || load_use;
    // Gated by reset so every output reads 0 while reset is held.
    assign flush        = bus.BRANCH_TAKEN && RST_N;
    assign bubble       = stall_active || flush;

    assign bus.STALL_FETCH    = stall_active && !flush;
    assign bus.STALL_DECODE   = stall_active && !flush;
    assign bus.BUBBLE_EXECUTE = bubble;
    assign bus.FLUSH_DECODE   = flush;
    assign bus.FWD_A_SEL      = fwd_a_q;
    assign bus.FWD_B_SEL      = fwd_b_q;
    assign bus.STALL_COUNT    = stall_count;
    assign bus.FLUSH_COUNT    = flush_count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the scoreboard is a handful of flops, not a RAM, so it is
            // reset; the first instruction after reset must see it empty.
            sb          <= '{default: SB_EMPTY};
            stall_left  <= 2'd0;
            fwd_a_q     <= FWD_REGFILE;
            fwd_b_q     <= FWD_REGFILE;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            sb[2]      <= sb[SB_MEM];
            sb[SB_MEM] <= sb[SB_EX];
            sb[SB_EX]  <= bubble ? SB_EMPTY : dec_entry;

            fwd_a_q <= bubble ? FWD_REGFILE
                              : fwd_select(dec_rs1, dec_cls.rs1_used, sb[SB_EX], sb[SB_MEM]);
            fwd_b_q <= bubble ? FWD_REGFILE
                              : fwd_select(dec_rs2, dec_cls.rs2_used, sb[SB_EX], sb[SB_MEM]);

            if (flush)
                stall_left <= 2'd0;
            else if (stall_left != 2'd0)
                stall_left <= stall_left - 2'd1;
            else if (load_use)
                stall_left <= STALL_RELOAD;

            if (bus.STALL_DECODE && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if (flush && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    // Scoreboard invariant: an entry without a write is fully empty, and a
    // write never targets x0.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            assert (sb[i].wr_en ? (sb[i].rd != 5'd0) : (sb[i] == SB_EMPTY));
        end
    end

endmodule
